// File: rtl/mini_src_datapath_p.sv
// Mini-SRC datapath: one-hot shared bus, register file, fetch sequencer
// with req/ack memory handshake and sticky bus-contention flag.
module mini_src_datapath_p #(
    parameter int DATA_W = 32,
    parameter int REG_COUNT = 16,
    parameter int PC_STEP = 1,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int C_W = 19,
    localparam int RW = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                in_clr_n,
    input  logic [7:0]          in_src_sel,
    input  logic [RW-1:0]       in_reg_sel,
    input  logic                in_ba_out,
    input  logic                in_reg_write,
    input  logic                in_hi_write,
    input  logic                in_lo_write,
    input  logic                in_y_write,
    input  logic                in_z_write,
    input  logic                in_pc_write,
    input  logic                in_mar_write,
    input  logic                in_ir_write,
    input  logic                in_mdr_write,
    input  logic                in_mdr_select,
    input  logic [2*DATA_W-1:0] in_alu_result,
    input  logic                in_fetch_start,
    input  logic                in_mem_ack,
    input  logic [DATA_W-1:0]   in_mem_data,
    output logic [DATA_W-1:0]   out_bus,
    output logic [DATA_W-1:0]   out_y,
    output logic [DATA_W-1:0]   out_mar,
    output logic [DATA_W-1:0]   out_mdr,
    output logic [DATA_W-1:0]   out_ir,
    output logic                out_mem_req,
    output logic                out_busy,
    output logic                out_fetch_done,
    output logic                out_bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

    state_t                state;
    logic [DATA_W-1:0]     rf [REG_COUNT];
    logic [DATA_W-1:0]     hi, lo, pc;
    logic [2*DATA_W-1:0]   z;
    logic [DATA_W-1:0]     rf_rd, c_ext, bus;
    logic                  multi, ext_ok;

    // ext_ok gates every external strobe; the sequencer owns the
    // datapath from the start cycle until it returns to IDLE.
    assign ext_ok = (state == IDLE) && !in_fetch_start;

    always_comb begin
        rf_rd = (in_ba_out && in_reg_sel == '0) ? '0 : rf[in_reg_sel];
        c_ext = {{(DATA_W-C_W){out_ir[C_W-1]}}, out_ir[C_W-1:0]};
        multi = |(in_src_sel & (in_src_sel - 8'd1));
        bus = '0;
        if (!multi) begin
            unique case (1'b1)
                in_src_sel[0]: bus = rf_rd;
                in_src_sel[1]: bus = hi;
                in_src_sel[2]: bus = lo;
                in_src_sel[3]: bus = z[2*DATA_W-1:DATA_W];
                in_src_sel[4]: bus = z[DATA_W-1:0];
                in_src_sel[5]: bus = pc;
                in_src_sel[6]: bus = out_mdr;
                in_src_sel[7]: bus = c_ext;
                default:       bus = '0;
            endcase
        end
    end

    assign out_bus = bus;

    always_ff @(posedge clk or negedge in_clr_n) begin
        if (!in_clr_n) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
            hi          <= '0;
            lo          <= '0;
            out_y       <= '0;
            z           <= '0;
            out_bus_err <= 1'b0;
        end else begin
            if (multi) out_bus_err <= 1'b1;
            if (ext_ok) begin
                if (in_reg_write) rf[in_reg_sel] <= bus;
                if (in_hi_write) hi <= bus;
                if (in_lo_write) lo <= bus;
                if (in_y_write) out_y <= bus;
                if (in_z_write) z <= in_alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge in_clr_n) begin
        if (!in_clr_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            out_mar        <= '0;
            out_mdr        <= '0;
            out_ir         <= '0;
            out_mem_req    <= 1'b0;
            out_busy       <= 1'b0;
            out_fetch_done <= 1'b0;
        end else begin
            out_fetch_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_fetch_start) begin
                        out_mar     <= pc;
                        out_mem_req <= 1'b1;
                        out_busy    <= 1'b1;
                        state       <= REQ;
                    end else begin
                        if (in_pc_write) pc <= bus;
                        if (in_mar_write) out_mar <= bus;
                        if (in_ir_write) out_ir <= bus;
                        if (in_mdr_write)
                            out_mdr <= in_mdr_select ? in_mem_data : bus;
                    end
                end
                REQ: begin
                    if (in_mem_ack) begin
                        out_mdr     <= in_mem_data;
                        pc          <= pc + DATA_W'(PC_STEP);
                        out_mem_req <= 1'b0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    out_ir         <= out_mdr;
                    out_busy       <= 1'b0;
                    out_fetch_done <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mini_src_datapath_p.sv
// Scoreboard bench for mini_src_datapath_p: reset, fetch timing,
// write blocking, bus contention, C extension, PC wrap and Z halves.
module tb_mini_src_datapath_p;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [7:0]  src_sel;
    logic [3:0]  reg_sel;
    logic        ba_out, reg_wr, hi_wr, lo_wr, y_wr, z_wr;
    logic        pc_wr, mar_wr, ir_wr, mdr_wr, mdr_sel;
    logic [63:0] alu;
    logic        fetch_start, mem_ack;
    logic [31:0] mem_data;
    logic [31:0] bus, y, mar, mdr, ir;
    logic        mem_req, busy, done, bus_err;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    string       nm_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mini_src_datapath_p dut (
        .clk(clk), .in_clr_n(clr_n), .in_src_sel(src_sel),
        .in_reg_sel(reg_sel), .in_ba_out(ba_out),
        .in_reg_write(reg_wr), .in_hi_write(hi_wr), .in_lo_write(lo_wr),
        .in_y_write(y_wr), .in_z_write(z_wr), .in_pc_write(pc_wr),
        .in_mar_write(mar_wr), .in_ir_write(ir_wr), .in_mdr_write(mdr_wr),
        .in_mdr_select(mdr_sel), .in_alu_result(alu),
        .in_fetch_start(fetch_start), .in_mem_ack(mem_ack),
        .in_mem_data(mem_data), .out_bus(bus), .out_y(y), .out_mar(mar),
        .out_mdr(mdr), .out_ir(ir), .out_mem_req(mem_req), .out_busy(busy),
        .out_fetch_done(done), .out_bus_err(bus_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        src_sel = '0; reg_wr = 0; hi_wr = 0; lo_wr = 0; y_wr = 0;
        z_wr = 0; pc_wr = 0; mar_wr = 0; ir_wr = 0; mdr_wr = 0;
        mdr_sel = 0; fetch_start = 0; mem_ack = 0; ba_out = 0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        mem_data = v; mdr_sel = 1; mdr_wr = 1;
        cyc();
        clear_strobes();
    endtask

    task automatic write_pc(input logic [31:0] v);
        load_mdr(v);
        src_sel = 8'h40; pc_wr = 1;
        cyc();
        clear_strobes();
    endtask

    task automatic write_ir(input logic [31:0] v);
        load_mdr(v);
        src_sel = 8'h40; ir_wr = 1;
        cyc();
        clear_strobes();
    endtask

    task automatic expect_v(input string s, input logic [31:0] e);
        nm_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] e, o; string s;
        clr_n = 0; clear_strobes();
        reg_sel = 0; alu = '0; mem_data = '0;
        cyc(); cyc();
        expect_v("rst_ir", 32'h0); obs_q.push_back(ir);
        expect_v("rst_err", 32'h0); obs_q.push_back({31'b0, bus_err});
        clr_n = 1;
        cyc();
        write_pc(32'd5);
        write_ir(32'd7);
        src_sel = 8'h20; #1;
        expect_v("pc_eq5", 32'd5); obs_q.push_back(bus);
        expect_v("ir_eq7", 32'd7); obs_q.push_back(ir);
        src_sel = 0; fetch_start = 1;
        cyc();
        fetch_start = 0;
        cyc();
        expect_v("req_mid", 32'd1); obs_q.push_back({31'b0, mem_req});
        clr_n = 0; #1;
        expect_v("rst_req", 32'd0); obs_q.push_back({31'b0, mem_req});
        expect_v("rst_busy", 32'd0); obs_q.push_back({31'b0, busy});
        expect_v("rst_ir2", 32'd0); obs_q.push_back(ir);
        src_sel = 8'h20; #1;
        expect_v("rst_pc", 32'd0); obs_q.push_back(bus);
        clr_n = 1; src_sel = 0;
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", s, o, e);
            end
        end
    endtask

    task automatic test_fetch_fast();
        logic [31:0] e, o; string s;
        write_pc(32'h10);
        mem_data = 32'hA5A5_A5A5; fetch_start = 1;
        cyc();
        fetch_start = 0;
        expect_v("ff_mar", 32'h10); obs_q.push_back(mar);
        expect_v("ff_req", 32'd1); obs_q.push_back({31'b0, mem_req});
        expect_v("ff_busy", 32'd1); obs_q.push_back({31'b0, busy});
        mem_ack = 1;
        cyc();
        mem_ack = 0; src_sel = 8'h20; #1;
        expect_v("ff_pc", 32'h11); obs_q.push_back(bus);
        expect_v("ff_mdr", 32'hA5A5_A5A5); obs_q.push_back(mdr);
        expect_v("ff_req0", 32'd0); obs_q.push_back({31'b0, mem_req});
        expect_v("ff_ir_pre", 32'h0); obs_q.push_back(ir);
        cyc();
        expect_v("ff_ir", 32'hA5A5_A5A5); obs_q.push_back(ir);
        expect_v("ff_done", 32'd1); obs_q.push_back({31'b0, done});
        expect_v("ff_idle", 32'd0); obs_q.push_back({31'b0, busy});
        cyc();
        expect_v("ff_done0", 32'd0); obs_q.push_back({31'b0, done});
        src_sel = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", s, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, o; string s;
        int cnt;
        write_pc(32'h20);
        load_mdr(32'h77);
        fetch_start = 1;
        cyc();
        expect_v("bb_mar", 32'h20); obs_q.push_back(mar);
        src_sel = 8'h40; pc_wr = 1;
        mem_data = 32'h1234_5678;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) cnt++;
            mem_ack = (i == 3);
            cyc();
        end
        mem_ack = 0; fetch_start = 0; pc_wr = 0;
        expect_v("bb_reqcnt", 32'd4); obs_q.push_back(32'(cnt));
        expect_v("bb_req0", 32'd0); obs_q.push_back({31'b0, mem_req});
        src_sel = 8'h20; #1;
        expect_v("bb_pc", 32'h21); obs_q.push_back(bus);
        cyc();
        expect_v("bb_ir", 32'h1234_5678); obs_q.push_back(ir);
        expect_v("bb_done", 32'd1); obs_q.push_back({31'b0, done});
        fetch_start = 1;
        cyc();
        fetch_start = 0;
        expect_v("bb_restart", 32'd1); obs_q.push_back({31'b0, busy});
        expect_v("bb_mar2", 32'h21); obs_q.push_back(mar);
        mem_ack = 1; mem_data = 32'hCAFE_0001;
        cyc();
        mem_ack = 0;
        cyc();
        expect_v("bb_ir2", 32'hCAFE_0001); obs_q.push_back(ir);
        mem_ack = 1; mem_data = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 0; #1;
        expect_v("bb_stray_mdr", 32'hCAFE_0001); obs_q.push_back(mdr);
        expect_v("bb_stray_pc", 32'h22); obs_q.push_back(bus);
        expect_v("bb_stray_busy", 32'd0); obs_q.push_back({31'b0, busy});
        src_sel = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", s, o, e);
            end
        end
    endtask

    task automatic test_bus();
        logic [31:0] e, o; string s;
        src_sel = 0; #1;
        expect_v("bus_none", 32'h0); obs_q.push_back(bus);
        expect_v("err_clean", 32'd0); obs_q.push_back({31'b0, bus_err});
        src_sel = 8'b0010_0001; #1;
        expect_v("bus_multi", 32'h0); obs_q.push_back(bus);
        cyc();
        expect_v("err_set", 32'd1); obs_q.push_back({31'b0, bus_err});
        src_sel = 0;
        cyc();
        expect_v("err_sticky", 32'd1); obs_q.push_back({31'b0, bus_err});
        clr_n = 0; #1;
        expect_v("err_rst", 32'd0); obs_q.push_back({31'b0, bus_err});
        clr_n = 1;
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", s, o, e);
            end
        end
    endtask

    task automatic test_cext_regs();
        logic [31:0] e, o; string s;
        write_ir(32'h0004_0000);
        src_sel = 8'h80; #1;
        expect_v("cext_neg", 32'hFFFC_0000); obs_q.push_back(bus);
        write_ir(32'hFFF3_FFFF);
        src_sel = 8'h80; #1;
        expect_v("cext_pos", 32'h0003_FFFF); obs_q.push_back(bus);
        load_mdr(32'h55);
        src_sel = 8'h40; reg_sel = 0; reg_wr = 1;
        cyc();
        clear_strobes();
        src_sel = 8'h01; ba_out = 1; #1;
        expect_v("r0_ba", 32'h0); obs_q.push_back(bus);
        ba_out = 0; #1;
        expect_v("r0_read", 32'h55); obs_q.push_back(bus);
        y_wr = 1;
        cyc();
        y_wr = 0;
        expect_v("y_load", 32'h55); obs_q.push_back(y);
        load_mdr(32'h99);
        src_sel = 8'h40; reg_sel = 3; reg_wr = 1;
        cyc();
        clear_strobes();
        src_sel = 8'h01; ba_out = 1; mar_wr = 1; #1;
        expect_v("r3_ba", 32'h99); obs_q.push_back(bus);
        expect_v("mar_hold", 32'h0); obs_q.push_back(mar);
        cyc();
        clear_strobes();
        expect_v("mar_edge", 32'h99); obs_q.push_back(mar);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", s, o, e);
            end
        end
    endtask

    task automatic test_wrap_z();
        logic [31:0] e, o; string s;
        write_pc(32'hFFFF_FFFF);
        fetch_start = 1;
        cyc();
        fetch_start = 0; mem_ack = 1; mem_data = 32'h0BAD_F00D;
        cyc();
        mem_ack = 0;
        cyc();
        src_sel = 8'h20; #1;
        expect_v("pc_wrap", 32'h0); obs_q.push_back(bus);
        expect_v("wrap_ir", 32'h0BAD_F00D); obs_q.push_back(ir);
        src_sel = 0; alu = 64'h1_0000_0002; z_wr = 1;
        cyc();
        z_wr = 0; alu = '0;
        src_sel = 8'h08; #1;
        expect_v("z_hi", 32'h1); obs_q.push_back(bus);
        lo_wr = 1;
        cyc();
        lo_wr = 0;
        src_sel = 8'h10; #1;
        expect_v("z_lo", 32'h2); obs_q.push_back(bus);
        hi_wr = 1;
        cyc();
        hi_wr = 0;
        src_sel = 8'h02; #1;
        expect_v("hi_reg", 32'h2); obs_q.push_back(bus);
        src_sel = 8'h04; #1;
        expect_v("lo_reg", 32'h1); obs_q.push_back(bus);
        src_sel = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", s, o, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_fast();
        test_back_to_back();
        test_bus();
        test_cext_regs();
        test_wrap_z();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mini_src_datapath_p.md
Name: mini_src_datapath_p

Overview:
- Parametrised next-generation Mini-SRC datapath: configurable data width, register count and PC step.
- Keeps the single shared bus with one-hot source selection. Adds a built-in instruction-fetch sequencer with a req/ack memory handshake, a properly registered MAR, and sticky bus-contention detection.
- ALU is external: the block exports Y and the bus and takes the ALU result back into Z.
- Sits between the control unit and the memory subsystem.

Parameters:
- DATA_W, 32, width of bus and all data registers.
- REG_COUNT, 16, number of general registers; power of two, at least 2.
- PC_STEP, 1, increment applied to PC on each fetch.
- RESET_PC, 0, PC value after reset.
- C_W, 19, width of the IR immediate field (IR[C_W-1:0]); sign-extended onto the bus.

Ports:
- clk  in  1  rising-edge clock.
- in_clr_n  in  1  asynchronous active-low reset.
- in_src_sel  in  8  one-hot bus source: [0]=regfile, [1]=HI, [2]=LO, [3]=Z_hi, [4]=Z_lo, [5]=PC, [6]=MDR, [7]=C sign-extended.
- in_reg_sel  in  log2(REG_COUNT)  register index, used for both read and write.
- in_ba_out  in  1  when high and in_reg_sel==0, the regfile read returns 0.
- in_reg_write, in_hi_write, in_lo_write, in_y_write, in_z_write, in_pc_write, in_mar_write, in_ir_write, in_mdr_write  in  1 each  external write strobes.
- in_mdr_select  in  1  MDR source for an external write: 0=bus, 1=in_mem_data.
- in_alu_result  in  2*DATA_W  ALU result; captured into Z.
- in_fetch_start  in  1  start a fetch; sampled only in IDLE.
- in_mem_ack  in  1  memory acknowledge; in_mem_data is valid in the ack cycle.
- in_mem_data  in  DATA_W  memory read data.
- out_bus  out  DATA_W  current bus value.
- out_y  out  DATA_W  Y register, feeds the ALU A operand.
- out_mar  out  DATA_W  memory address.
- out_mdr  out  DATA_W  MDR contents.
- out_ir  out  DATA_W  IR contents.
- out_mem_req  out  1  memory read request.
- out_busy  out  1  fetch sequencer not in IDLE.
- out_fetch_done  out  1  one-cycle pulse when IR holds the new instruction.
- out_bus_err  out  1  sticky flag: more than one bus source selected.

Behaviour:
- Reset (asynchronous, in_clr_n low):
  - All registers, Y, Z, HI, LO, MAR, MDR and IR go to 0; PC goes to RESET_PC.
  - State goes to IDLE; out_mem_req, out_busy, out_fetch_done and out_bus_err go to 0.
  - Reset mid-fetch aborts the fetch immediately; req drops without waiting for a clock edge.
- Bus (combinational):
  - Exactly one in_src_sel bit set: bus carries that source.
  - Zero bits set: bus = 0 (never X).
  - More than one bit set: bus = 0, and out_bus_err is set at the next edge; it clears only on reset.
- C sign extension: bus = IR[C_W-1:0] sign-extended from IR[C_W-1] to DATA_W.
- Z: in_z_write captures in_alu_result. Z_hi = Z[2*DATA_W-1:DATA_W], Z_lo = Z[DATA_W-1:0].
- External writes:
  - All update on the clock edge from the bus, except MDR when in_mdr_select=1, which takes in_mem_data.
  - MAR is a true register: it changes only on an edge, never combinationally.
- Write blocking: every external write strobe is ignored when the state is not IDLE, or when in_fetch_start=1 in IDLE. In those cycles only the fetch sequencer writes PC, MAR, MDR and IR.
- Fetch FSM, IDLE -> REQ -> LOAD -> IDLE:
  - IDLE: in_fetch_start=1 at edge E0 -> MAR<=PC, go to REQ.
  - REQ: out_mem_req=1, held until an edge where in_mem_ack=1. At that edge: MDR<=in_mem_data, PC<=PC+PC_STEP (mod 2^DATA_W), go to LOAD. An ack outside REQ is ignored.
  - LOAD: at the next edge, IR<=MDR, go to IDLE, and out_fetch_done is registered high for the following cycle only.
  - Minimum latency: start sampled at E0, ack at E1, IR valid and done high after E2.
- out_busy = 1 in REQ and LOAD.
- in_fetch_start while busy is ignored; it is not queued.
- A new in_fetch_start during the done cycle (state IDLE) is accepted normally.
- PC wrap: PC = 2^DATA_W - PC_STEP fetches and becomes 0.

Test Plan:
- Reset: PC=5, IR=7, then in_clr_n low mid-REQ -> immediately PC=RESET_PC, IR=0, out_mem_req=0, out_busy=0.
- Fetch with ack in the first REQ cycle: PC=0x10, in_mem_data=0xA5A5A5A5 -> out_mar=0x10; after E1, PC=0x11 and MDR=0xA5A5A5A5; after E2, out_ir=0xA5A5A5A5 and out_fetch_done high for exactly 1 cycle.
- Fetch with ack delayed 3 cycles, with in_pc_write=1 and in_fetch_start=1 during REQ -> req held 4 cycles, PC increments exactly once, external write and second start ignored.
- Bus: in_src_sel=0 -> bus=0. Then in_src_sel=8'b0010_0001 -> bus=0 and out_bus_err=1, which stays 1 after in_src_sel=0; only reset clears it.
- C extension: IR=0x0004_0000 (bit18=1), in_src_sel[7] -> bus=0xFFFC_0000. R0 with in_ba_out=1 holding 0x55 -> bus=0.
- Wrap and Z: PC=0xFFFF_FFFF, fetch -> PC=0. in_alu_result=0x1_0000_0002 with in_z_write, then Z_hi -> bus=1 and Z_lo -> bus=2.
